// File: rtl/spi_register_controller_if.sv
// spi_register_controller_if: SPI-slave and register-file signals seen by the frame controller.
// master is the controller view; slave is the surrounding SPI slave / register file view.
interface spi_register_controller_if #(
    parameter int ADDR_W = 4
);
    logic              csN;
    logic              byteDone;
    logic [7:0]        rxByte;
    logic [7:0]        txByte;
    logic [ADDR_W-1:0] regAddr;
    logic [7:0]        regWdata;
    logic              regWe;
    logic [7:0]        regRdata;
    logic              busy;
    logic              err;
    logic              errClr;

    modport master (
        input  csN, byteDone, rxByte, regRdata, errClr,
        output txByte, regAddr, regWdata, regWe, busy, err
    );

    modport slave (
        output csN, byteDone, rxByte, regRdata, errClr,
        input  txByte, regAddr, regWdata, regWe, busy, err
    );
endinterface

// File: rtl/spi_register_controller.sv
// spi_register_controller: decodes SPI frames (command + data bytes) into register file accesses.
// Define SPI_CTRL_AUTOINC_EN to advance the address after every data byte (burst access).
module spi_register_controller #(
    parameter int NUM_REGS    = 16,
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    spi_register_controller_if.master bus
);
    typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} stateE;

    stateE                  state, stateNext;
    logic [SYNC_STAGES-1:0] csSync, bdSync, fill;
    logic                   bdSd, armed;
    logic                   csS, bdS, bdRise, inRange;
    logic                   cmdLatch, wrByte, rdByte;
    logic                   loadTx, advPend, regWe, err;
    logic [6:0]             addr, nextAddr;
    logic [7:0]             txByte, regWdata;

    assign csS     = csSync[SYNC_STAGES-1];
    assign bdS     = bdSync[SYNC_STAGES-1];
    assign bdRise  = bdS & ~bdSd;
    assign inRange = {1'b0, addr} < 8'(NUM_REGS);

`ifdef SPI_CTRL_AUTOINC_EN
    assign nextAddr = (addr == 7'(NUM_REGS - 1)) ? 7'd0 : addr + 7'd1;
`else
    assign nextAddr = addr;
`endif

    assign bus.txByte   = txByte;
    assign bus.regAddr  = addr[ADDR_W-1:0];
    assign bus.regWdata = regWdata;
    assign bus.regWe    = regWe;
    assign bus.busy     = state != IDLE;
    assign bus.err      = err;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= stateNext;

    always_comb begin
        stateNext = state;
        cmdLatch  = 1'b0;
        wrByte    = 1'b0;
        rdByte    = 1'b0;
        case (state)
            IDLE:    stateNext = (armed && !csS) ? CMD : IDLE;
            CMD: begin
                cmdLatch  = bdRise;
                stateNext = bdRise ? (bus.rxByte[7] ? WRITE : READ) : CMD;
            end
            WRITE:   wrByte = bdRise;
            default: rdByte = bdRise;
        endcase
        if (state != IDLE && csS) stateNext = IDLE;
    end

    // armed only once a real high CS has crossed the synchroniser, so a frame
    // already open when reset releases is ignored
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            csSync   <= '1;
            bdSync   <= '0;
            fill     <= '0;
            bdSd     <= 1'b0;
            armed    <= 1'b0;
            addr     <= '0;
            txByte   <= '0;
            regWdata <= '0;
            regWe    <= 1'b0;
            advPend  <= 1'b0;
            loadTx   <= 1'b0;
            err      <= 1'b0;
        end else begin
            csSync   <= {csSync[SYNC_STAGES-2:0], bus.csN};
            bdSync   <= {bdSync[SYNC_STAGES-2:0], bus.byteDone};
            fill     <= {fill[SYNC_STAGES-2:0], 1'b1};
            bdSd     <= bdS;
            armed    <= armed | (csS & fill[SYNC_STAGES-1]);
            regWe    <= wrByte & inRange;
            advPend  <= wrByte;
            loadTx   <= cmdLatch | rdByte;
            err      <= ((loadTx | wrByte) & ~inRange) | (err & ~bus.errClr);
            if (wrByte) regWdata <= bus.rxByte;
            // writes advance one CLK late so regAddr holds during the strobe
            if (cmdLatch)               addr <= bus.rxByte[6:0];
            else if (rdByte || advPend) addr <= nextAddr;
            if (loadTx)             txByte <= inRange ? bus.regRdata : 8'h00;
            else if (state == IDLE) txByte <= 8'h00;
        end
endmodule
